// File: rtl/multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl
//
// Purpose:
//   Control FSM for a multi-cycle fetch/decode/execute datapath. It sequences
//   the instruction-memory request, IR load, one decode-settle cycle, execute,
//   the data-memory handshake and register writeback. Both memory handshakes
//   are guarded by a bounded-wait watchdog. Any watchdog expiry, or a decode
//   that asks for a load and a store together, parks the FSM in a terminal
//   FAULT state until reset.
//
// Parameters:
//   MEM_TIMEOUT  maximum cycles a request waits for its ack (1..255)
//   CNT_W        width of the retired-instruction counter
//
// Optional feature macro:
//   MULTICYCLE_PERF_CNT_EN  when defined, 'retired' counts completed
//                           instructions (wrapping modulo 2^CNT_W); when
//                           undefined there are no counter flops and
//                           'retired' is tied to 0.
//
// Ports:
//   clk           system clock, rising edge
//   reset         asynchronous, active-low reset
//   run           allow a new instruction (sampled in IDLE and at completion)
//   i_ack         instruction word valid
//   uncondbranch  decode flag: unconditional branch
//   branch        decode flag: CBZ-style conditional branch
//   mem_read      decode flag: load
//   mem_write     decode flag: store
//   zero          ALU zero flag, valid in EXECUTE
//   d_ack         data memory transfer complete
//   i_req         instruction fetch request (FETCH)
//   ir_write      IR load pulse
//   d_req         data memory request (MEM)
//   d_we          data memory write enable (MEM and store)
//   reg_write     register file write pulse (WB)
//   pc_write      PC update pulse (instruction completion)
//   pc_src        0 = incremented PC, 1 = branch target
//   state         current FSM state encoding
//   mem_fault     sticky fault indication
//   retired       completed instruction count
// ---------------------------------------------------------------------------
module multicycle_ctrl #(
   parameter int unsigned MEM_TIMEOUT = 15,
   parameter int unsigned CNT_W       = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             run,
   input  logic             i_ack,
   input  logic             uncondbranch,
   input  logic             branch,
   input  logic             mem_read,
   input  logic             mem_write,
   input  logic             zero,
   input  logic             d_ack,
   output logic             i_req,
   output logic             ir_write,
   output logic             d_req,
   output logic             d_we,
   output logic             reg_write,
   output logic             pc_write,
   output logic             pc_src,
   output logic [2:0]       state,
   output logic             mem_fault,
   output logic [CNT_W-1:0] retired
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_FETCH   = 3'd1,
      S_DECODE  = 3'd2,
      S_EXECUTE = 3'd3,
      S_MEM     = 3'd4,
      S_WB      = 3'd5,
      S_FAULT   = 3'd6
   } state_t;

   // The watchdog value seen during the last permitted wait cycle. An ack on
   // that cycle still completes the handshake; no ack sends us to FAULT.
   localparam logic [7:0] WD_LAST = 8'(MEM_TIMEOUT - 1);

   state_t     state_q, state_d;
   logic [7:0] wd_q, wd_d;
   logic       done;
   logic       waiting;

   // State and watchdog registers. Reset is asynchronous so in-flight
   // requests drop the moment reset asserts.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         wd_q    <= 8'd0;
      end else begin
         state_q <= state_d;
         wd_q    <= wd_d;
      end
   end

   // Next-state logic plus the Mealy pulses. 'done' marks instruction
   // completion: the PC is written and run decides FETCH versus IDLE.
   // 'waiting' is only set on cycles that stay in FETCH or MEM without an ack,
   // so every state change clears the watchdog.
   always_comb begin
      state_d   = state_q;
      ir_write  = 1'b0;
      pc_write  = 1'b0;
      pc_src    = 1'b0;
      reg_write = 1'b0;
      done      = 1'b0;
      waiting   = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (run) state_d = S_FETCH;
         end
         S_FETCH: begin
            if (i_ack) begin
               ir_write = 1'b1;
               state_d  = S_DECODE;
            end else if (wd_q == WD_LAST) begin
               state_d = S_FAULT;
            end else begin
               waiting = 1'b1;
            end
         end
         S_DECODE: begin
            state_d = S_EXECUTE;
         end
         S_EXECUTE: begin
            if (mem_read && mem_write) begin
               state_d = S_FAULT;
            end else if (uncondbranch || (branch && zero)) begin
               pc_src = 1'b1;
               done   = 1'b1;
            end else if (branch) begin
               done = 1'b1;
            end else if (mem_read || mem_write) begin
               state_d = S_MEM;
            end else begin
               state_d = S_WB;
            end
         end
         S_MEM: begin
            if (d_ack) begin
               if (mem_read) state_d = S_WB;
               else          done    = 1'b1;
            end else if (wd_q == WD_LAST) begin
               state_d = S_FAULT;
            end else begin
               waiting = 1'b1;
            end
         end
         S_WB: begin
            reg_write = 1'b1;
            done      = 1'b1;
         end
         S_FAULT: begin
            state_d = S_FAULT;
         end
         default: begin
            state_d = S_FAULT;
         end
      endcase

      if (done) begin
         pc_write = 1'b1;
         state_d  = run ? S_FETCH : S_IDLE;
      end

      wd_d = waiting ? (wd_q + 8'd1) : 8'd0;
   end

   // Moore outputs depend only on the registered state. FAULT is terminal,
   // so decoding it directly gives a sticky fault flag.
   assign i_req     = (state_q == S_FETCH);
   assign d_req     = (state_q == S_MEM);
   assign d_we      = (state_q == S_MEM) && mem_write;
   assign mem_fault = (state_q == S_FAULT);
   assign state     = state_q;

`ifdef MULTICYCLE_PERF_CNT_EN
   logic [CNT_W-1:0] retired_q;

   // Retired-instruction counter; wraps naturally at 2^CNT_W.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         retired_q <= '0;
      end else if (done) begin
         retired_q <= retired_q + CNT_W'(1);
      end
   end

   assign retired = retired_q;
`else
   assign retired = '0;
`endif

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multi-cycle control FSM that sequences the fetch/decode datapath: instruction-memory request, IR load, decode settle, execute, data-memory handshake and register writeback.
- Consumes the control flags produced by decode and the ALU zero flag.
- Produces per-stage enables, the PC select and memory requests.
- Adds a bounded-wait watchdog on both memory handshakes.

Parameters:
- MEM_TIMEOUT, 15: max cycles a request may wait for ack before fault (1..255).
- CNT_W, 32: width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- run  in  1  allow a new instruction to start; sampled only in IDLE and at instruction completion
- i_ack  in  1  instruction word valid from instruction memory
- uncondbranch  in  1  decode flag, valid from DECODE onward
- branch  in  1  decode flag (CBZ-style)
- mem_read  in  1  decode flag, load
- mem_write  in  1  decode flag, store
- zero  in  1  ALU zero, valid in EXECUTE
- d_ack  in  1  data memory transfer complete
- i_req  out  1  instruction fetch request
- ir_write  out  1  load instruction register (1-cycle pulse)
- d_req  out  1  data memory request
- d_we  out  1  data memory write enable
- reg_write  out  1  register file write (1-cycle pulse)
- pc_write  out  1  update PC (1-cycle pulse)
- pc_src  out  1  0 = incremented PC, 1 = branch_target
- state  out  3  current FSM state encoding
- mem_fault  out  1  sticky watchdog/illegal-decode fault
- retired  out  CNT_W  completed instruction count

Behaviour:
- Reset (reset=0, async): state=IDLE, watchdog=0, mem_fault=0, retired=0, all outputs 0. In-flight requests drop immediately; no partial pc_write or reg_write.
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEM=4, WB=5, FAULT=6.
- Moore outputs (from registered state only):
  - i_req=1 in FETCH.
  - d_req=1 in MEM.
  - d_we=mem_write in MEM.
- Mealy pulses: ir_write, pc_write, pc_src and reg_write are combinational from state plus inputs, asserted for exactly one cycle.
- "Done" means: pc_write=1 this cycle; next state is FETCH if run=1, else IDLE; retired increments.
- IDLE: run=1 -> FETCH.
- FETCH:
  - i_ack=1 -> ir_write=1, go to DECODE.
  - No ack -> watchdog++.
- DECODE: fixed 1 cycle -> EXECUTE. Decode flags may settle during this cycle.
- EXECUTE, priority order:
  1. mem_read&mem_write -> FAULT, mem_fault=1.
  2. uncondbranch, or branch&zero -> pc_src=1, done.
  3. branch&!zero -> pc_src=0, done.
  4. mem_read|mem_write -> MEM.
  5. Otherwise -> WB.
- MEM:
  - d_ack=1 and mem_read -> WB.
  - d_ack=1 and store -> pc_src=0, done.
  - No ack -> watchdog++.
- WB: reg_write=1, pc_src=0, done.
- Watchdog:
  - Cleared on every state change.
  - Reaching MEM_TIMEOUT while still unacked -> FAULT, mem_fault=1.
  - Ack in the same cycle the count hits the limit: ack wins, no fault.
- FAULT: terminal until reset. All enables and requests 0; mem_fault held 1; state=6.
- Latency without waits: ALU op 4 cycles (FETCH, DECODE, EXECUTE, WB); branch 3; store 4; load 5. Each memory wait cycle adds 1.
- run deasserted mid-instruction: the current instruction completes, then the FSM parks in IDLE.
- retired wraps modulo 2^CNT_W.

Optional Feature:
- Macro: MULTICYCLE_PERF_CNT_EN.
- Defined: retired counter implemented as above.
- Undefined: no counter flops; retired driven constant 0; port retained so the interface is unchanged.

Test Plan:
- ALU op: run=1, i_ack on 1st FETCH cycle, all flags 0 -> ir_write at cycle 1, reg_write+pc_write (pc_src=0) at cycle 4, state returns to 1; retired=1.
- Taken CBZ: branch=1, zero=1 -> pc_write=1 with pc_src=1 in EXECUTE; reg_write never asserted; 3 cycles total.
- Load with d_ack delayed 3 cycles -> d_req high 4 cycles, d_we=0, then WB reg_write=1; 8 cycles total.
- Store with no d_ack, MEM_TIMEOUT=15 -> FAULT (state=6) and mem_fault=1 after 15 wait cycles; d_ack arriving on cycle 15 instead -> no fault, pc_write pulse.
- Illegal decode mem_read=mem_write=1 -> FAULT next cycle; outputs stay 0 until reset; reset=0 returns state=0, mem_fault=0.
- reset asserted while d_req=1 -> d_req falls without waiting for a clock edge; run=0 during WB -> state=IDLE after done; with macro undefined, retired stays 0.
